tree_walker: RTL and testbench
==============================

# tree_walker

Sequential navigator over a message-hierarchy tree held in an internal node table of LEVELS rows × SLOTS slots. Software or a loader fills the table through a write port. The decoder then issues descend, ascend and root commands; the block tracks the current node, the current level and the full path from the root. This replaces the combinational tree helpers with a registered, parametrised walker that scans one slot per cycle and reports miss, overflow and underflow.

## Interface
- ID_W, 8: node-id width; id 0 is the null/root id.
- LEVELS, 4: number of hierarchy levels (table rows, path depth).
- SLOTS, 8: nodes per level; SLOT_W = $clog2(SLOTS), LVL_W = $clog2(LEVELS+1).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- tbl_wr_en  in  1  write one table entry.
- tbl_wr_level  in  LVL_W  row index.
- tbl_wr_slot  in  SLOT_W  slot index.
- tbl_wr_node_id  in  ID_W  node id (0 clears the slot).
- tbl_wr_parent_id  in  ID_W  parent node id (0 = root).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with rst low.
- cmd_op  in  2  0 DESCEND, 1 ASCEND, 2 ROOT, 3 NOP.
- cmd_id  in  ID_W  target child id for DESCEND.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_status  out  2  0 OK, 1 MISS, 2 OVERFLOW, 3 UNDERFLOW; valid with rsp_valid.
- cur_node_id  out  ID_W  current node (0 at root).
- cur_level  out  LVL_W  depth; equals the row searched by the next DESCEND.
- path_o  out  LEVELS*ID_W  path; entry i at bits [i*ID_W +: ID_W]; entries ≥ cur_level are 0.

## Operation
- The FSM has three states: IDLE, SCAN and RESP. A command is accepted on a clock edge with cmd_valid & cmd_ready.
- **DESCEND:**
  - If cur_level == LEVELS: go to RESP with status OVERFLOW.
  - Otherwise enter SCAN with slot counter 0. Each SCAN cycle compares row[cur_level][slot].
  - A hit requires node_id == cmd_id, node_id != 0 and parent_id == cur_node_id.
  - On a hit: path[cur_level] = cmd_id, cur_node_id = cmd_id, cur_level + 1, status OK.
  - If the last slot misses: status MISS and the walker state is unchanged.
  - The lowest matching slot wins; scanning stops at the first hit.
  - cmd_id == 0 always gives MISS after the full scan.
- **ASCEND:**
  - If cur_level == 0: status UNDERFLOW, no change.
  - Otherwise cur_level − 1 and path[cur_level−1] = 0.
  - cur_node_id becomes path[cur_level−2], or 0 when the new level is 0. Status OK.
- **ROOT:** cur_level = 0, cur_node_id = 0, all path entries 0, status OK.
- **NOP:** status OK, no change.
- Walker registers (cur_node_id, cur_level, path_o) update on the same edge that raises rsp_valid.
- **Table writes:**
  - Accepted in any state and take effect at the edge.
  - A SCAN compares the registered table contents. A write to a slot not yet scanned is visible; a write to a slot already passed is not.
  - Writes with tbl_wr_level ≥ LEVELS or tbl_wr_slot ≥ SLOTS are ignored.
- **Reset:**
  - Clears the table, the path, cur_node_id and cur_level.
  - Drives rsp_valid = 0, rsp_status = 0 and cmd_ready = 0; the FSM returns to IDLE.
  - Reset mid-SCAN aborts the command with no response.
  - cmd_ready = 1 from the first cycle after rst deasserts.

## Timing
- cmd_ready is 0 in SCAN and RESP, so only one command is in flight.
- Accept edge is T0.
  - Non-scanning ops (ASCEND, ROOT, NOP, OVERFLOW): rsp_valid high in cycle T0+1.
  - DESCEND hit in slot k: SCAN cycles T0+1 … T0+1+k, rsp_valid high in cycle T0+2+k.
  - DESCEND miss: rsp_valid high in cycle T0+1+SLOTS.
- rsp_valid lasts exactly one cycle. cmd_ready returns the cycle after RESP, so back-to-back commands have at least one idle gap.
- There is no rsp back-pressure; the consumer must sample the response on the pulse.

## Test plan
- **Reset then idle:** cmd_ready=0 during rst, 1 after. cur_level=0, cur_node_id=0, path_o=0.
- **Descend chain:**
  - Load row0 slot2 {id 5, parent 0} and row1 slot0 {id 9, parent 5}.
  - DESCEND 5 → OK, rsp at T0+4, level 1, path[0]=5.
  - DESCEND 9 → OK at T0+2, cur=9, level 2.
- **Miss and wrong parent:**
  - Load row0 slot0 {id 7, parent 3}.
  - DESCEND 7 from root → MISS at T0+1+SLOTS, state unchanged.
- **Overflow and underflow:**
  - With LEVELS=4 at level 4, DESCEND → OVERFLOW with no change.
  - ROOT, then ASCEND → UNDERFLOW at T0+1.
- **Ascend restore:** from path {5,9,12}, ASCEND → cur=9, level 2, path[2]=0. ASCEND → cur=5. ASCEND → cur=0.
- **Mid-scan write and reset:**
  - During a DESCEND 4 scan at slot 1, write row0 slot3 {4,0} → OK with rsp at T0+5.
  - Repeat with rst asserted mid-SCAN → no rsp_valid, all outputs return to 0.

Source files
------------

// File: rtl/tree_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tree_walker
//  Purpose  : Registered navigator over a LEVELS x SLOTS message-hierarchy
//             node table. Executes DESCEND / ASCEND / ROOT / NOP commands,
//             scanning one table slot per cycle, and tracks the current node,
//             the current depth and the full path from the root.
//  Revision : 1.0  initial release
// ============================================================================
module tree_walker #(
   parameter int ID_W   = 8,
   parameter int LEVELS = 4,
   parameter int SLOTS  = 8,
   parameter int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
   parameter int LVL_W  = $clog2(LEVELS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   // table write port
   input  logic                   tbl_wr_en,
   input  logic [LVL_W-1:0]       tbl_wr_level,
   input  logic [SLOT_W-1:0]      tbl_wr_slot,
   input  logic [ID_W-1:0]        tbl_wr_node_id,
   input  logic [ID_W-1:0]        tbl_wr_parent_id,
   // command channel
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [ID_W-1:0]        cmd_id,
   // response
   output logic                   rsp_valid,
   output logic [1:0]             rsp_status,
   // walker state
   output logic [ID_W-1:0]        cur_node_id,
   output logic [LVL_W-1:0]       cur_level,
   output logic [LEVELS*ID_W-1:0] path_o
);

   // Row index width; a level value is only used as a row index once it is
   // known to be below LEVELS, so the upper bit(s) can be dropped safely.
   localparam int LIDX_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

   localparam logic [1:0] C_OP_DESCEND = 2'd0;
   localparam logic [1:0] C_OP_ASCEND  = 2'd1;
   localparam logic [1:0] C_OP_ROOT    = 2'd2;

   localparam logic [1:0] C_ST_OK        = 2'd0;
   localparam logic [1:0] C_ST_MISS      = 2'd1;
   localparam logic [1:0] C_ST_OVERFLOW  = 2'd2;
   localparam logic [1:0] C_ST_UNDERFLOW = 2'd3;

   localparam logic [LVL_W-1:0]  C_LEVELS    = LVL_W'(LEVELS);
   localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(SLOTS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [ID_W-1:0]     tgt_id_q, tgt_id_d;
   logic [1:0]          status_q, status_d;
   logic [ID_W-1:0]     node_q, node_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [ID_W-1:0]     path_q [LEVELS];
   logic [ID_W-1:0]     path_d [LEVELS];

   logic [ID_W-1:0]     node_tbl_q   [LEVELS][SLOTS];
   logic [ID_W-1:0]     parent_tbl_q [LEVELS][SLOTS];

   logic                w_wr_ok;
   logic [LIDX_W-1:0]   w_row;
   logic [ID_W-1:0]     w_slot_node;
   logic [ID_W-1:0]     w_slot_parent;
   logic                w_hit;
   logic [LVL_W-1:0]    w_lvl_m1;
   logic [LVL_W-1:0]    w_lvl_m2;

   // Out-of-range coordinates must not alias onto a real row or slot.
   assign w_wr_ok = tbl_wr_en
                    && (32'(tbl_wr_level) < 32'(LEVELS))
                    && (32'(tbl_wr_slot)  < 32'(SLOTS));

   assign w_row         = level_q[LIDX_W-1:0];
   assign w_slot_node   = node_tbl_q[w_row][slot_q];
   assign w_slot_parent = parent_tbl_q[w_row][slot_q];
   assign w_hit         = (w_slot_node == tgt_id_q) && (w_slot_node != '0)
                          && (w_slot_parent == node_q);
   assign w_lvl_m1      = level_q - LVL_W'(1);
   assign w_lvl_m2      = level_q - LVL_W'(2);

   // Node table: cleared by reset, otherwise one entry written per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < LEVELS; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
               node_tbl_q[l][s]   <= '0;
               parent_tbl_q[l][s] <= '0;
            end
         end
      end else if (w_wr_ok) begin
         node_tbl_q[tbl_wr_level[LIDX_W-1:0]][tbl_wr_slot]   <= tbl_wr_node_id;
         parent_tbl_q[tbl_wr_level[LIDX_W-1:0]][tbl_wr_slot] <= tbl_wr_parent_id;
      end
   end

   // Control and walker state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         slot_q   <= '0;
         tgt_id_q <= '0;
         status_q <= C_ST_OK;
         node_q   <= '0;
         level_q  <= '0;
         for (int i = 0; i < LEVELS; i++) begin
            path_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         tgt_id_q <= tgt_id_d;
         status_q <= status_d;
         node_q   <= node_d;
         level_q  <= level_d;
         for (int i = 0; i < LEVELS; i++) begin
            path_q[i] <= path_d[i];
         end
      end
   end

   // Next-state logic; walker registers change on the edge entering RESP.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      tgt_id_d = tgt_id_q;
      status_d = status_q;
      node_d   = node_q;
      level_d  = level_q;
      for (int i = 0; i < LEVELS; i++) begin
         path_d[i] = path_q[i];
      end

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d  = S_RESP;
               status_d = C_ST_OK;
               case (cmd_op)
                  C_OP_DESCEND: begin
                     if (level_q == C_LEVELS) begin
                        status_d = C_ST_OVERFLOW;
                     end else begin
                        state_d  = S_SCAN;
                        slot_d   = '0;
                        tgt_id_d = cmd_id;
                     end
                  end
                  C_OP_ASCEND: begin
                     if (level_q == '0) begin
                        status_d = C_ST_UNDERFLOW;
                     end else begin
                        level_d                      = w_lvl_m1;
                        path_d[w_lvl_m1[LIDX_W-1:0]] = '0;
                        if (w_lvl_m1 == '0) begin
                           node_d = '0;
                        end else begin
                           node_d = path_q[w_lvl_m2[LIDX_W-1:0]];
                        end
                     end
                  end
                  C_OP_ROOT: begin
                     level_d = '0;
                     node_d  = '0;
                     for (int i = 0; i < LEVELS; i++) begin
                        path_d[i] = '0;
                     end
                  end
                  default: begin
                     // NOP: respond OK with no state change
                  end
               endcase
            end
         end
         S_SCAN: begin
            if (w_hit) begin
               state_d       = S_RESP;
               status_d      = C_ST_OK;
               path_d[w_row] = tgt_id_q;
               node_d        = tgt_id_q;
               level_d       = level_q + LVL_W'(1);
            end else if (slot_q == C_LAST_SLOT) begin
               state_d  = S_RESP;
               status_d = C_ST_MISS;
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cmd_ready   = (state_q == S_IDLE) && !rst;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_status  = status_q;
   assign cur_node_id = node_q;
   assign cur_level   = level_q;

   // Flatten the path registers onto the output bus, entry 0 in the LSBs.
   for (genvar gi = 0; gi < LEVELS; gi++) begin : g_path
      assign path_o[gi*ID_W +: ID_W] = path_q[gi];
   end

endmodule
`default_nettype wire

// File: tb/tb_tree_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tree_walker
//  Purpose  : Directed self-checking bench for tree_walker (ID_W=8,
//             LEVELS=4, SLOTS=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tree_walker;

   logic        clk;
   logic        rst;
   logic        tbl_wr_en;
   logic [2:0]  tbl_wr_level;
   logic [2:0]  tbl_wr_slot;
   logic [7:0]  tbl_wr_node_id;
   logic [7:0]  tbl_wr_parent_id;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_id;
   logic        rsp_valid;
   logic [1:0]  rsp_status;
   logic [7:0]  cur_node_id;
   logic [2:0]  cur_level;
   logic [31:0] path_o;

   int checks;
   int failures;
   int lat;
   logic [1:0] st;

   tree_walker #(.ID_W(8), .LEVELS(4), .SLOTS(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .tbl_wr_en        (tbl_wr_en),
      .tbl_wr_level     (tbl_wr_level),
      .tbl_wr_slot      (tbl_wr_slot),
      .tbl_wr_node_id   (tbl_wr_node_id),
      .tbl_wr_parent_id (tbl_wr_parent_id),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_id           (cmd_id),
      .rsp_valid        (rsp_valid),
      .rsp_status       (rsp_status),
      .cur_node_id      (cur_node_id),
      .cur_level        (cur_level),
      .path_o           (path_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One table write, occupying one clock edge.
   task automatic tbl_write(input logic [2:0] lvl, input logic [2:0] slot,
                            input logic [7:0] id, input logic [7:0] par);
      tbl_wr_en = 1'b1; tbl_wr_level = lvl; tbl_wr_slot = slot;
      tbl_wr_node_id = id; tbl_wr_parent_id = par;
      step();
      tbl_wr_en = 1'b0;
   endtask

   // Issue one command; lat = n means rsp_valid seen in cycle T0+n (0 = none).
   task automatic do_cmd(input logic [1:0] op, input logic [7:0] id,
                         output int l, output logic [1:0] s);
      int guard;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         step();
         guard++;
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_id = id;
      step();
      cmd_valid = 1'b0; cmd_op = 2'd3; cmd_id = 8'd0;
      l = 0;
      s = 2'd0;
      for (int n = 1; n <= 40; n++) begin
         if (rsp_valid) begin
            l = n;
            s = rsp_status;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rspv got=%b exp=0", rsp_valid); end
      rst = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", cmd_ready); end
      checks++; if (cur_level !== 3'd0) begin failures++; $display("FAIL post_rst_level got=%0d exp=0", cur_level); end
      checks++; if (cur_node_id !== 8'd0) begin failures++; $display("FAIL post_rst_node got=%0d exp=0", cur_node_id); end
      checks++; if (path_o !== 32'h0) begin failures++; $display("FAIL post_rst_path got=%h exp=0", path_o); end
      step();
   endtask

   task automatic test_descend_chain();
      tbl_write(3'd0, 3'd2, 8'd5, 8'd0);
      tbl_write(3'd1, 3'd0, 8'd9, 8'd5);
      tbl_write(3'd2, 3'd5, 8'd12, 8'd9);
      do_cmd(2'd0, 8'd5, lat, st);
      checks++; if (lat !== 4) begin failures++; $display("FAIL desc5_lat got=%0d exp=4", lat); end
      checks++; if (st !== 2'd0) begin failures++; $display("FAIL desc5_status got=%0d exp=0", st); end
      checks++; if (cur_level !== 3'd1) begin failures++; $display("FAIL desc5_level got=%0d exp=1", cur_level); end
      checks++; if (path_o !== 32'h0000_0005) begin failures++; $display("FAIL desc5_path got=%h exp=00000005", path_o); end
      do_cmd(2'd0, 8'd9, lat, st);
      checks++; if (lat !== 2) begin failures++; $display("FAIL desc9_lat got=%0d exp=2", lat); end
      checks++; if (cur_node_id !== 8'd9) begin failures++; $display("FAIL desc9_node got=%0d exp=9", cur_node_id); end
      checks++; if (cur_level !== 3'd2) begin failures++; $display("FAIL desc9_level got=%0d exp=2", cur_level); end
      do_cmd(2'd0, 8'd12, lat, st);
      checks++; if (lat !== 7) begin failures++; $display("FAIL desc12_lat got=%0d exp=7", lat); end
      checks++; if (path_o !== 32'h000C_0905) begin failures++; $display("FAIL desc12_path got=%h exp=000c0905", path_o); end
      // Back-to-back: busy during RESP, one-cycle pulse, ready next cycle.
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL resp_ready got=%b exp=0", cmd_ready); end
      step();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b exp=0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_return got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_ascend_restore();
      do_cmd(2'd1, 8'd0, lat, st);
      checks++; if (lat !== 1 || st !== 2'd0) begin failures++; $display("FAIL asc1_rsp got=lat%0d/st%0d exp=lat1/st0", lat, st); end
      checks++; if (cur_node_id !== 8'd9 || cur_level !== 3'd2) begin failures++; $display("FAIL asc1_state got=%0d/%0d exp=9/2", cur_node_id, cur_level); end
      checks++; if (path_o !== 32'h0000_0905) begin failures++; $display("FAIL asc1_path got=%h exp=00000905", path_o); end
      do_cmd(2'd1, 8'd0, lat, st);
      checks++; if (cur_node_id !== 8'd5 || cur_level !== 3'd1) begin failures++; $display("FAIL asc2_state got=%0d/%0d exp=5/1", cur_node_id, cur_level); end
      do_cmd(2'd1, 8'd0, lat, st);
      checks++; if (cur_node_id !== 8'd0 || cur_level !== 3'd0 || path_o !== 32'h0) begin failures++; $display("FAIL asc3_state got=%0d/%0d/%h exp=0/0/0", cur_node_id, cur_level, path_o); end
   endtask

   task automatic test_miss();
      tbl_write(3'd0, 3'd0, 8'd7, 8'd3);
      do_cmd(2'd0, 8'd7, lat, st);
      checks++; if (lat !== 9) begin failures++; $display("FAIL miss7_lat got=%0d exp=9", lat); end
      checks++; if (st !== 2'd1) begin failures++; $display("FAIL miss7_status got=%0d exp=1", st); end
      checks++; if (cur_level !== 3'd0 || cur_node_id !== 8'd0 || path_o !== 32'h0) begin failures++; $display("FAIL miss7_state got=%0d/%0d/%h exp=0/0/0", cur_level, cur_node_id, path_o); end
      do_cmd(2'd0, 8'd0, lat, st);
      checks++; if (lat !== 9 || st !== 2'd1) begin failures++; $display("FAIL miss0_rsp got=lat%0d/st%0d exp=lat9/st1", lat, st); end
      // Level 4 is out of range and must not land in row 0.
      tbl_write(3'd4, 3'd1, 8'd50, 8'd0);
      do_cmd(2'd0, 8'd50, lat, st);
      checks++; if (st !== 2'd1 || cur_level !== 3'd0) begin failures++; $display("FAIL oor_write got=st%0d/lvl%0d exp=st1/lvl0", st, cur_level); end
   endtask

   task automatic test_overflow_underflow();
      tbl_write(3'd3, 3'd7, 8'd33, 8'd12);
      do_cmd(2'd0, 8'd5, lat, st);
      do_cmd(2'd0, 8'd9, lat, st);
      do_cmd(2'd0, 8'd12, lat, st);
      do_cmd(2'd0, 8'd33, lat, st);
      checks++; if (lat !== 9 || st !== 2'd0) begin failures++; $display("FAIL desc33_rsp got=lat%0d/st%0d exp=lat9/st0", lat, st); end
      checks++; if (cur_level !== 3'd4 || path_o !== 32'h210C_0905) begin failures++; $display("FAIL full_state got=%0d/%h exp=4/210c0905", cur_level, path_o); end
      do_cmd(2'd0, 8'd33, lat, st);
      checks++; if (lat !== 1 || st !== 2'd2) begin failures++; $display("FAIL ovf_rsp got=lat%0d/st%0d exp=lat1/st2", lat, st); end
      checks++; if (cur_level !== 3'd4 || cur_node_id !== 8'd33 || path_o !== 32'h210C_0905) begin failures++; $display("FAIL ovf_state got=%0d/%0d/%h exp=4/33/210c0905", cur_level, cur_node_id, path_o); end
      do_cmd(2'd3, 8'd0, lat, st);
      checks++; if (lat !== 1 || st !== 2'd0 || cur_level !== 3'd4) begin failures++; $display("FAIL nop got=lat%0d/st%0d/lvl%0d exp=1/0/4", lat, st, cur_level); end
      do_cmd(2'd2, 8'd0, lat, st);
      checks++; if (lat !== 1 || cur_level !== 3'd0 || cur_node_id !== 8'd0 || path_o !== 32'h0) begin failures++; $display("FAIL root got=lat%0d/%0d/%0d/%h exp=1/0/0/0", lat, cur_level, cur_node_id, path_o); end
      do_cmd(2'd1, 8'd0, lat, st);
      checks++; if (lat !== 1 || st !== 2'd3) begin failures++; $display("FAIL udf_rsp got=lat%0d/st%0d exp=lat1/st3", lat, st); end
      checks++; if (cur_level !== 3'd0) begin failures++; $display("FAIL udf_level got=%0d exp=0", cur_level); end
   endtask

   task automatic test_midscan_write();
      int n;
      while (!cmd_ready) step();
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_id = 8'd4;
      step();                                   // T0 edge; now in T0+1 (slot 0)
      cmd_valid = 1'b0; cmd_op = 2'd3; cmd_id = 8'd0;
      step();                                   // T0+2: scanning slot 1
      tbl_wr_en = 1'b1; tbl_wr_level = 3'd0; tbl_wr_slot = 3'd3;
      tbl_wr_node_id = 8'd4; tbl_wr_parent_id = 8'd0;
      step();                                   // T0+3
      tbl_wr_en = 1'b0;
      lat = 0;
      for (n = 3; n <= 30; n++) begin
         if (rsp_valid) begin
            lat = n;
            st = rsp_status;
            break;
         end
         step();
      end
      checks++; if (lat !== 5) begin failures++; $display("FAIL midwr_lat got=%0d exp=5", lat); end
      checks++; if (st !== 2'd0 || cur_node_id !== 8'd4 || cur_level !== 3'd1) begin failures++; $display("FAIL midwr_state got=st%0d/%0d/%0d exp=0/4/1", st, cur_node_id, cur_level); end
   endtask

   task automatic test_reset_midscan();
      int seen;
      do_cmd(2'd2, 8'd0, lat, st);
      while (!cmd_ready) step();
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_id = 8'd4;
      step();
      cmd_valid = 1'b0; cmd_op = 2'd3; cmd_id = 8'd0;
      step();                                   // mid-SCAN
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (rsp_valid) seen++;
      end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst2_ready got=%b exp=0", cmd_ready); end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rsp_valid) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst2_norsp got=%0d exp=0", seen); end
      checks++; if (cur_level !== 3'd0 || cur_node_id !== 8'd0 || path_o !== 32'h0 || rsp_status !== 2'd0) begin failures++; $display("FAIL rst2_outputs got=%0d/%0d/%h/%0d exp=0/0/0/0", cur_level, cur_node_id, path_o, rsp_status); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst2_ready_after got=%b exp=1", cmd_ready); end
      // Table was cleared, so a previously present node now misses.
      do_cmd(2'd0, 8'd5, lat, st);
      checks++; if (lat !== 9 || st !== 2'd1) begin failures++; $display("FAIL rst2_tbl got=lat%0d/st%0d exp=lat9/st1", lat, st); end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      tbl_wr_en = 1'b0; tbl_wr_level = 3'd0; tbl_wr_slot = 3'd0;
      tbl_wr_node_id = 8'd0; tbl_wr_parent_id = 8'd0;
      cmd_valid = 1'b0; cmd_op = 2'd3; cmd_id = 8'd0;
      #1;
      test_reset();
      test_descend_chain();
      test_ascend_restore();
      test_miss();
      test_overflow_underflow();
      test_midscan_write();
      test_reset_midscan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
